// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared encodings for the write-back stage: RV32I load funct3
//               codes, FSM state encoding and load lane widths.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Load size/sign encodings carried in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Write-back FSM states
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;

    // Lane widths used when slicing the raw memory word
    localparam int unsigned c_BYTE_W = 8;
    localparam int unsigned c_HALF_W = 16;
    localparam int unsigned c_WORD_W = 32;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load lane select and sign/zero extension, plus
//               a fault flag for misaligned addresses or unknown funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_raw_data,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_fault
);

    logic [c_WORD_W-1:0] w_word;
    logic [c_BYTE_W-1:0] w_byte;
    logic [c_HALF_W-1:0] w_half;

    // Only the low 32-bit word carries sub-word lanes; halves use addr_lo[1]
    assign w_word = i_raw_data[c_WORD_W-1:0];
    assign w_byte = w_word[{i_addr_lo, 3'b000} +: c_BYTE_W];
    assign w_half = w_word[{i_addr_lo[1], 4'b0000} +: c_HALF_W];

    // Extend the selected lane to the full datapath width
    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_LB:   o_load_data = XLEN'($signed(w_byte));
            F3_LH:   o_load_data = XLEN'($signed(w_half));
            F3_LW:   o_load_data = XLEN'($signed(w_word));
            F3_LBU:  o_load_data = XLEN'(w_byte);
            F3_LHU:  o_load_data = XLEN'(w_half);
            default: o_load_data = '0;
        endcase
    end

    // Flag natural-alignment violations and encodings that are not loads
    always_comb begin
        o_fault = 1'b1;
        case (i_funct3)
            F3_LB, F3_LBU: o_fault = 1'b0;
            F3_LH, F3_LHU: o_fault = i_addr_lo[0];
            F3_LW:         o_fault = |i_addr_lo;
            default:       o_fault = 1'b1;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/write_back_stage.sv
`default_nettype none
// ============================================================================
// Module      : write_back_stage
// Description : RV32I write-back stage. Retires one instruction at a time,
//               waits for load data, aligns/extends it and drives a
//               registered register-file write port and retire/error pulses.
//               Optional macro WB_INSTRET_EN adds a 64-bit retired counter.
// Revision    : 1.0 - initial release
// ============================================================================
module write_back_stage
    import wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_is_load,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              retire,
`ifdef WB_INSTRET_EN
    output logic [63:0]       instret,
`endif
    output logic              wb_error
);

    // Counter only needs to hold 0 .. MEM_TIMEOUT-1
    localparam int unsigned c_TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST =
        c_TMO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    logic [0:0]         r_state;
    logic [REG_AW-1:0]  r_rd;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;
    logic [c_TMO_W-1:0] r_tmo_cnt;

    logic               w_idle;
    logic               w_accept;
    logic               w_alu_done;
    logic               w_ld_start;
    logic               w_ld_fault;
    logic               w_ld_done;
    logic               w_tmo_last;
    logic               w_tmo_evt;
    logic [2:0]         w_al_funct3;
    logic [1:0]         w_al_addr_lo;
    logic [XLEN-1:0]    w_load_data;
    logic               w_fault;

    assign w_idle   = (r_state == ST_IDLE);
    assign in_ready = enable && w_idle;
    assign w_accept = in_valid && in_ready;

    // In IDLE the aligner checks the incoming request; while waiting it
    // formats the response using the captured funct3/addr_lo.
    assign w_al_funct3  = w_idle ? in_funct3  : r_funct3;
    assign w_al_addr_lo = w_idle ? in_addr_lo : r_addr_lo;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_funct3    (w_al_funct3),
        .i_addr_lo   (w_al_addr_lo),
        .i_raw_data  (mem_rsp_data),
        .o_load_data (w_load_data),
        .o_fault     (w_fault)
    );

    generate
        if (MEM_TIMEOUT > 0) begin : g_tmo_on
            assign w_tmo_last = (r_tmo_cnt == c_TMO_LAST);
        end else begin : g_tmo_off
            assign w_tmo_last = 1'b0;
        end
    endgenerate

    assign w_alu_done = w_accept && !in_is_load;
    assign w_ld_fault = w_accept && in_is_load && w_fault;
    assign w_ld_start = w_accept && in_is_load && !w_fault;
    assign w_ld_done  = enable && !w_idle && mem_rsp_valid;
    // A response on the final waiting cycle wins over the timeout
    assign w_tmo_evt  = enable && !w_idle && !mem_rsp_valid && w_tmo_last;

    // FSM, request capture and memory timeout counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_tmo_cnt <= '0;
        end else if (enable) begin
            if (w_accept) begin
                r_rd      <= in_rd;
                r_funct3  <= in_funct3;
                r_addr_lo <= in_addr_lo;
            end
            if (w_ld_start) begin
                r_state   <= ST_WAIT_MEM;
                r_tmo_cnt <= '0;
            end else if (w_ld_done || w_tmo_evt) begin
                r_state   <= ST_IDLE;
                r_tmo_cnt <= '0;
            end else if (!w_idle && (MEM_TIMEOUT > 0)) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
        end
    end

    // Registered write port and single-cycle retire/error pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            retire   <= 1'b0;
            wb_error <= 1'b0;
        end else if (enable) begin
            rf_we    <= 1'b0;
            retire   <= 1'b0;
            wb_error <= 1'b0;
            if (w_alu_done) begin
                rf_we    <= (in_rd != '0);
                rf_waddr <= in_rd;
                rf_wdata <= in_result;
                retire   <= 1'b1;
            end else if (w_ld_done) begin
                rf_we    <= (r_rd != '0);
                rf_waddr <= r_rd;
                rf_wdata <= w_load_data;
                retire   <= 1'b1;
            end else if (w_ld_fault || w_tmo_evt) begin
                wb_error <= 1'b1;
            end
        end
    end

`ifdef WB_INSTRET_EN
    // Retired-instruction counter; wraps naturally at 2^64
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (w_alu_done || w_ld_done) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule : write_back_stage
`default_nettype wire

// File: tb/tb_write_back_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_back_stage
// Description : Scoreboard bench for write_back_stage. A driver issues
//               directed and random instructions and pushes the expected
//               outcome; a monitor pops and compares on every output pulse.
//               Honours WB_INSTRET_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_back_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int TMO    = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd = '0;
    logic [XLEN-1:0]   in_result = '0;
    logic              in_is_load = 1'b0;
    logic [2:0]        in_funct3 = '0;
    logic [1:0]        in_addr_lo = '0;
    logic              mem_rsp_valid = 1'b0;
    logic [XLEN-1:0]   mem_rsp_data = '0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              retire;
    logic              wb_error;
`ifdef WB_INSTRET_EN
    logic [63:0]       instret;
`endif

    write_back_stage #(
        .XLEN        (XLEN),
        .REG_AW      (REG_AW),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_result     (in_result),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .retire        (retire),
`ifdef WB_INSTRET_EN
        .instret       (instret),
`endif
        .wb_error      (wb_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        is_err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t            exp_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    longint unsigned n_retired = 0;
    logic            en_q = 1'b0;
    logic [39:0]     prev_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_fault(input logic [2:0] f3, input logic [1:0] alo);
        int size;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    return 1'b1;
        endcase
        return (int'(alo) % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] alo,
                                              input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(alo))) & 32'hFF;
        h = (w >> (16 * (int'(alo) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            default: return h;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clock) en_q = enable;

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && en_q) begin
            if (rf_we || retire || wb_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {61'd0, rf_we, retire, wb_error}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        check("err_pulse", wb_error, 1);
                        check("err_no_we", rf_we, 0);
                        check("err_no_retire", retire, 0);
                    end else begin
                        n_retired++;
                        check("retire", retire, 1);
                        check("no_err_on_retire", wb_error, 0);
                        check("rf_we", rf_we, (e.rd != 0));
                        check("rf_waddr", rf_waddr, e.rd);
                        check("rf_wdata", rf_wdata, e.data);
                    end
                end
            end
        end else if (reset_n && !en_q) begin
            check("hold_outputs", {rf_we, retire, wb_error, rf_waddr, rf_wdata}, prev_out);
        end
`ifdef WB_INSTRET_EN
        check("instret", instret, n_retired);
`endif
        prev_out = {rf_we, retire, wb_error, rf_waddr, rf_wdata};
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bit rand_en(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic issue(input logic [4:0] rd, input logic [31:0] result, input bit is_load,
                         input logic [2:0] f3, input logic [1:0] alo, input int rsp_k,
                         input logic [31:0] rsp_data, input int en_pct);
        bit accepted;
        bit done;
        int budget;
        int k;
        accepted   = 1'b0;
        budget     = 0;
        in_valid   = 1'b1;
        in_rd      = rd;
        in_result  = result;
        in_is_load = is_load;
        in_funct3  = f3;
        in_addr_lo = alo;
        while (!accepted) begin
            enable        = rand_en(en_pct);
            mem_rsp_valid = 1'($urandom_range(1));
            mem_rsp_data  = $urandom();
            #1;
            check("in_ready_idle", in_ready, enable);
            accepted = enable;
            step();
            budget++;
            if (!accepted && budget > 2000) begin
                check("accept_budget", 0, 1);
                return;
            end
        end
        if (!is_load) begin
            exp_q.push_back('{is_err: 1'b0, rd: rd, data: result});
        end else if (model_fault(f3, alo)) begin
            exp_q.push_back('{is_err: 1'b1, rd: rd, data: 32'd0});
        end else begin
            k    = 0;
            done = 1'b0;
            budget = 0;
            while (!done) begin
                // Unrelated request fields must not disturb the captured load
                in_valid   = 1'($urandom_range(1));
                in_rd      = 5'($urandom());
                in_is_load = 1'($urandom_range(1));
                in_funct3  = 3'($urandom());
                in_addr_lo = 2'($urandom());
                enable     = rand_en(en_pct);
                if (enable) begin
                    k++;
                    mem_rsp_valid = (k == rsp_k);
                    mem_rsp_data  = rsp_data;
                end else begin
                    mem_rsp_valid = 1'($urandom_range(1));
                    mem_rsp_data  = $urandom();
                end
                #1;
                check("in_ready_wait", in_ready, 0);
                step();
                if (enable && k == rsp_k) begin
                    exp_q.push_back('{is_err: 1'b0, rd: rd, data: model_load(f3, alo, rsp_data)});
                    done = 1'b1;
                end else if (enable && k == TMO) begin
                    exp_q.push_back('{is_err: 1'b1, rd: rd, data: 32'd0});
                    done = 1'b1;
                end
                budget++;
                if (!done && budget > 2000) begin
                    check("wait_budget", 0, 1);
                    done = 1'b1;
                end
            end
        end
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    logic [2:0] f3_tab [12] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};

    initial begin
        // Reset state
        enable = 1'b1;
        step();
        step();
        check("rst_rf_we", rf_we, 0);
        check("rst_retire", retire, 0);
        check("rst_wb_error", wb_error, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret, 0);
`endif
        reset_n = 1'b1;
        step();

        // Directed cases
        issue(5'd5, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0, 0, 32'd0, 100);
        issue(5'd6, 32'h0000_0001, 1'b0, 3'd0, 2'd0, 0, 32'd0, 100);
        issue(5'd7, 32'd0, 1'b1, 3'd0, 2'd3, 4, 32'h80FF_FF12, 100);    // LB  -> FFFFFF80
        issue(5'd8, 32'd0, 1'b1, 3'd5, 2'd2, 1, 32'hABCD_1234, 100);    // LHU -> 0000ABCD
        issue(5'd9, 32'd0, 1'b1, 3'd2, 2'd1, 1, 32'd0, 100);            // LW misaligned
        issue(5'd0, 32'd0, 1'b1, 3'd2, 2'd0, 2, 32'h0000_1234, 100);    // rd=0 load
        issue(5'd10, 32'd0, 1'b1, 3'd2, 2'd0, 1000, 32'd0, 100);        // timeout
        issue(5'd11, 32'd0, 1'b1, 3'd1, 2'd2, TMO, 32'h8001_7FFF, 100); // rsp on timeout cycle
        issue(5'd12, 32'd0, 1'b1, 3'd3, 2'd0, 1, 32'd0, 100);           // illegal funct3
        issue(5'd13, 32'h1357_9BDF, 1'b0, 3'd0, 2'd0, 0, 32'd0, 100);
        enable = 1'b1;
        step();

        // Reset while waiting for memory, then a late response
        in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'd2; in_addr_lo = 2'd0; in_rd = 5'd9;
        #1;
        check("in_ready_pre_rst_load", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (3) begin
            #1;
            check("in_ready_wait_pre_rst", in_ready, 0);
            step();
        end
        reset_n   = 1'b0;
        n_retired = 0;
        #1;
        check("midrst_rf_we", rf_we, 0);
        check("midrst_retire", retire, 0);
        check("midrst_rf_wdata", rf_wdata, 0);
        step();
        step();
        reset_n       = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        step();
        mem_rsp_valid = 1'b0;
        check("late_rsp_no_we", rf_we, 0);
        check("late_rsp_no_retire", retire, 0);
        check("late_rsp_rf_wdata", rf_wdata, 0);
        check("late_rsp_idle", in_ready, 1);
        step();

        // Randomized traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            issue(5'($urandom()), $urandom(), 1'($urandom_range(1)),
                  f3_tab[$urandom_range(11)], 2'($urandom()),
                  int'($urandom_range(1, TMO + 2)), $urandom(), 75);
        end

        enable   = 1'b1;
        in_valid = 1'b0;
        repeat (4) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_write_back_stage
`default_nettype wire

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Parametrised write-back stage for the RV32I minimum core, sitting between the memory-access stage and the register file.
- Accepts one retiring instruction at a time over a valid/ready handshake.
- For loads, waits for the memory response, then aligns and sign- or zero-extends the data.
- Drives a single registered register-file write port and a one-cycle retire pulse.

Parameters:
- XLEN, 32, datapath width; 32 for RV32I, and must be 32 or 64.
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 255, maximum cycles spent in WAIT_MEM before the error abort; 0 disables the timeout.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global stall; when low, all state, counters and outputs hold
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept; high only in IDLE with enable high
- in_rd  in  REG_AW  destination register
- in_result  in  XLEN  ALU result, used for non-loads
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_addr_lo  in  2  low bits of the load address
- mem_rsp_valid  in  1  load data returned
- mem_rsp_data  in  XLEN  raw memory word
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  XLEN  write data
- retire  out  1  one-cycle pulse per completed instruction
- wb_error  out  1  one-cycle pulse on misaligned load, illegal funct3 or timeout

Behaviour:
- Reset (async assert, sync release): state IDLE; rf_we, retire and wb_error are 0; rf_waddr and rf_wdata are 0; the timeout counter is 0.
- All transitions are qualified by enable. With enable low, in_ready is 0 and mem_rsp_valid is ignored.
- Accept occurs when in_valid and in_ready are both high. in_rd, in_funct3 and in_addr_lo are captured at accept.
- IDLE, non-load accept:
  - Next cycle: rf_we=(in_rd!=0), rf_waddr=in_rd, rf_wdata=in_result, retire=1.
  - Latency is 1 cycle. State stays IDLE, so back-to-back accepts are allowed every cycle.
- IDLE, load accept:
  - Misaligned (LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0), or illegal funct3: next cycle wb_error=1, rf_we=0, retire=0. State stays IDLE.
  - Otherwise go to WAIT_MEM and clear the timeout counter.
- WAIT_MEM:
  - On mem_rsp_valid: select the byte lane as data[8*addr_lo +: 8] and the half lane as data[16*addr_lo[1] +: 16]. Extend per funct3 to XLEN.
  - Next cycle: rf_we=(rd!=0), rf_wdata=extended value, retire=1. State returns to IDLE.
  - in_ready is 0 throughout WAIT_MEM; minimum load latency is 2 cycles.
  - Timeout: the counter increments each enabled cycle. At MEM_TIMEOUT it pulses wb_error, writes nothing and returns to IDLE.
  - A mem_rsp_valid arriving in the same cycle as the timeout takes priority: the write happens and no error is raised.
- rd=0: retire still pulses; rf_we stays 0 and rf_wdata still updates.
- rf_we, retire and wb_error are single-cycle pulses and are never asserted together with wb_error.
- mem_rsp_valid in IDLE is ignored.
- Reset mid-WAIT_MEM abandons the load with no write. A late response after reset is ignored.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - Adds output instret (64 bits), reset to 0.
  - Increments by 1 on each retire pulse and wraps from 2^64-1 to 0.
  - Holds while enable is low; wb_error events do not count.
- Undefined: port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package wb_pkg:
  - funct3 load-encoding localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - State encoding ST_IDLE/ST_WAIT_MEM.
  - Lane-select helper width constants.
- Sub-module load_align: purely combinational inputs (funct3, addr_lo, raw data) producing aligned/extended data and a misalign/illegal flag. It is reused later by the store path.

Test Plan:
- Non-load back-to-back: accept rd=5, result=0xDEADBEEF, then rd=6, result=0x1 on consecutive cycles -> rf_we on cycles +1 and +2 with matching data; in_ready stays high; 2 retire pulses.
- LB, addr_lo=3, response 0x80FF_FF12 after 4 cycles -> rf_wdata=0xFFFFFF80, rf_we one cycle after mem_rsp_valid; in_ready=0 while waiting.
- LHU, addr_lo=2, response 0xABCD_1234 -> rf_wdata=0x0000ABCD. LW, addr_lo=1 -> wb_error pulse, no rf_we, no retire.
- rd=0 load with response 0x1234 -> retire=1, rf_we=0.
- MEM_TIMEOUT=8 with no response -> wb_error at the 8th waiting cycle, return to IDLE. Variant with the response arriving on the timeout cycle -> normal write and no error.
- reset_n low mid-WAIT_MEM, then a late mem_rsp_valid -> all outputs 0, no write. With WB_INSTRET_EN defined, instret equals the retire count across the whole test and holds while enable=0.
